vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_pkg.sv | 34 +++
 rtl/vram_arbiter_rr_grant.sv | 16 +
 rtl/vram_arbiter.sv | 155 +++++++++++++++
 tb/tb_vram_arbiter.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared video constants for the VRAM slot arbiter: slot map, RAM address
// width and byte-lane write-enable encoding.
package vram_arbiter_pkg;

    localparam int          SLOT_W  = 3;
    localparam int          RAM_AW  = 10;
    localparam logic [2:0]  SLOT_V0 = 3'd0;
    localparam logic [2:0]  SLOT_V1 = 3'd4;

    localparam logic [1:0]  WE_NONE = 2'b00;
    localparam logic [1:0]  WE_LO   = 2'b01;
    localparam logic [1:0]  WE_HI   = 2'b10;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_HS  = 1'b1
    } req_id_e;

    // Byte-lane enable for an 8-bit write into a 16-bit word.
    function automatic logic [1:0] lane_we(input logic we, input logic a0);
        if (!we) begin
            return WE_NONE;
        end else if (a0) begin
            return WE_HI;
        end else begin
            return WE_LO;
        end
    endfunction

    function automatic logic [7:0] lane_sel(input logic [15:0] d, input logic a0);
        return a0 ? d[15:8] : d[7:0];
    endfunction

endpackage

// File: rtl/vram_arbiter_rr_grant.sv
// Two-way round-robin grant: a sole requester always wins, a tie goes to
// whichever requester was not served last (last=1 means hiscore was last).
module vram_rr_grant (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Grant decode
    always_comb begin
        gnt    = 2'b00;
        gnt[0] = req[0] & (~req[1] | last);
        gnt[1] = req[1] & (~req[0] | ~last);
    end

endmodule

// File: rtl/vram_arbiter.sv
// Time-slotted VRAM arbiter: two fixed video fetch slots per 8-cycle frame,
// remaining six slots shared round-robin between the CPU and hiscore ports.
module vram_arbiter
    import vram_arbiter_pkg::*;
(
    input  logic              VCLKx8,
    input  logic              RESET,
    input  logic              slot_sync,
    input  logic [9:0]        vid0_ad,
    input  logic [9:0]        vid1_ad,
    output logic [15:0]       vid0_dt,
    output logic [15:0]       vid1_dt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [10:0]       cpu_ad,
    input  logic [7:0]        cpu_dw,
    output logic              cpu_ack,
    output logic [7:0]        cpu_dr,
    input  logic              hs_req,
    input  logic              hs_we,
    input  logic [10:0]       hs_ad,
    input  logic [7:0]        hs_dw,
    output logic              hs_ack,
    output logic [7:0]        hs_dr,
    input  logic              pause_n,
    output logic [RAM_AW-1:0] ram_ad,
    output logic [1:0]        ram_we,
    output logic [15:0]       ram_dw,
    input  logic [15:0]       ram_dr
);

    logic [SLOT_W-1:0] slot_q, slot_d;
    req_id_e           last_q, last_d;
    logic              cpu_ack_q, hs_ack_q;
    logic              cpu_rd_q, hs_rd_q;
    logic              cpu_sel_q, hs_sel_q;
    logic [7:0]        cpu_dr_q, hs_dr_q;
    logic [15:0]       vid0_q, vid1_q;
    logic [RAM_AW-1:0] ram_ad_q;

    logic              req_slot_s;
    logic [1:0]        elig_s;
    logic [1:0]        arb_req_s;
    logic [1:0]        gnt_s;

    // Eligibility: a requester being acked this cycle sits out, hiscore only while paused
    always_comb begin
        req_slot_s = (slot_q != SLOT_V0) && (slot_q != SLOT_V1);
        elig_s[0]  = cpu_req & ~cpu_ack_q;
        elig_s[1]  = hs_req & ~pause_n & ~hs_ack_q;
        if (req_slot_s) begin
            arb_req_s = elig_s;
        end else begin
            arb_req_s = 2'b00;
        end
    end

    vram_rr_grant u_rr (
        .req  (arb_req_s),
        .last (last_q == REQ_HS),
        .gnt  (gnt_s)
    );

    // RAM port mux, slot advance and round-robin pointer update
    always_comb begin
        ram_ad = ram_ad_q;
        ram_we = WE_NONE;
        ram_dw = 16'h0000;
        last_d = last_q;
        if (slot_q == SLOT_V0) begin
            ram_ad = vid0_ad;
        end else if (slot_q == SLOT_V1) begin
            ram_ad = vid1_ad;
        end else if (gnt_s[0]) begin
            ram_ad = cpu_ad[10:1];
            ram_we = lane_we(cpu_we, cpu_ad[0]);
            ram_dw = {cpu_dw, cpu_dw};
            last_d = REQ_CPU;
        end else if (gnt_s[1]) begin
            ram_ad = hs_ad[10:1];
            ram_we = lane_we(hs_we, hs_ad[0]);
            ram_dw = {hs_dw, hs_dw};
            last_d = REQ_HS;
        end else begin
            ram_ad = ram_ad_q;
        end

        if (slot_sync) begin
            slot_d = SLOT_V0;
        end else begin
            slot_d = slot_q + 3'd1;
        end
    end

    // Read data is live from the RAM in the ack cycle, then held
    always_comb begin
        if (cpu_ack_q && cpu_rd_q) begin
            cpu_dr = lane_sel(ram_dr, cpu_sel_q);
        end else begin
            cpu_dr = cpu_dr_q;
        end
        if (hs_ack_q && hs_rd_q) begin
            hs_dr = lane_sel(ram_dr, hs_sel_q);
        end else begin
            hs_dr = hs_dr_q;
        end
        cpu_ack = cpu_ack_q;
        hs_ack  = hs_ack_q;
        vid0_dt = vid0_q;
        vid1_dt = vid1_q;
    end

    // State registers
    always_ff @(posedge VCLKx8 or posedge RESET) begin
        if (RESET) begin
            slot_q    <= SLOT_V0;
            last_q    <= REQ_HS;
            cpu_ack_q <= 1'b0;
            hs_ack_q  <= 1'b0;
            cpu_rd_q  <= 1'b0;
            hs_rd_q   <= 1'b0;
            cpu_sel_q <= 1'b0;
            hs_sel_q  <= 1'b0;
            cpu_dr_q  <= 8'h00;
            hs_dr_q   <= 8'h00;
            vid0_q    <= 16'h0000;
            vid1_q    <= 16'h0000;
            ram_ad_q  <= '0;
        end else begin
            slot_q    <= slot_d;
            last_q    <= last_d;
            cpu_ack_q <= gnt_s[0];
            hs_ack_q  <= gnt_s[1];
            if (gnt_s[0]) begin
                cpu_rd_q  <= ~cpu_we;
                cpu_sel_q <= cpu_ad[0];
            end
            if (gnt_s[1]) begin
                hs_rd_q  <= ~hs_we;
                hs_sel_q <= hs_ad[0];
            end
            cpu_dr_q <= cpu_dr;
            hs_dr_q  <= hs_dr;
            ram_ad_q <= ram_ad;
            // Fetch issued in the video slot returns one cycle later
            if (slot_q == (SLOT_V0 + 3'd1)) begin
                vid0_q <= ram_dr;
            end
            if (slot_q == (SLOT_V1 + 3'd1)) begin
                vid1_q <= ram_dr;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: inputs change 1ns after each rising edge,
// outputs are sampled 3ns after it.
module tb_vram_arbiter;

    logic        VCLKx8;
    logic        RESET;
    logic        slot_sync;
    logic [9:0]  vid0_ad, vid1_ad;
    logic [15:0] vid0_dt, vid1_dt;
    logic        cpu_req, cpu_we, cpu_ack;
    logic [10:0] cpu_ad;
    logic [7:0]  cpu_dw, cpu_dr;
    logic        hs_req, hs_we, hs_ack;
    logic [10:0] hs_ad;
    logic [7:0]  hs_dw, hs_dr;
    logic        pause_n;
    logic [9:0]  ram_ad;
    logic [1:0]  ram_we;
    logic [15:0] ram_dw;
    logic [15:0] ram_dr;

    int checks = 0;
    int errors = 0;

    vram_arbiter dut (
        .VCLKx8(VCLKx8), .RESET(RESET), .slot_sync(slot_sync),
        .vid0_ad(vid0_ad), .vid1_ad(vid1_ad), .vid0_dt(vid0_dt), .vid1_dt(vid1_dt),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_ad(cpu_ad), .cpu_dw(cpu_dw),
        .cpu_ack(cpu_ack), .cpu_dr(cpu_dr),
        .hs_req(hs_req), .hs_we(hs_we), .hs_ad(hs_ad), .hs_dw(hs_dw),
        .hs_ack(hs_ack), .hs_dr(hs_dr), .pause_n(pause_n),
        .ram_ad(ram_ad), .ram_we(ram_we), .ram_dw(ram_dw), .ram_dr(ram_dr)
    );

    initial VCLKx8 = 1'b0;
    always #5 VCLKx8 = ~VCLKx8;

    task automatic cyc();
        @(posedge VCLKx8);
        #1;
    endtask

    // Leaves the bench 1ns into a slot-0 cycle
    task automatic align();
        slot_sync = 1'b1;
        cyc();
        slot_sync = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        cyc();
        cyc();
        #2;
        checks++;
        if (ram_we !== 2'b00) begin errors++; $display("FAIL rst_we: got %b expected %b", ram_we, 2'b00); end
        checks++;
        if (cpu_ack !== 1'b0 || hs_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b%b expected 00", cpu_ack, hs_ack); end
        checks++;
        if (cpu_dr !== 8'h00 || hs_dr !== 8'h00) begin errors++; $display("FAIL rst_dr: got %h %h expected 00 00", cpu_dr, hs_dr); end
        checks++;
        if (vid0_dt !== 16'h0000 || vid1_dt !== 16'h0000) begin errors++; $display("FAIL rst_vid: got %h %h expected 0000 0000", vid0_dt, vid1_dt); end
        cyc();
        RESET = 1'b0;
        cyc();
        align();
        cyc();
        // slot 1: CPU byte write to even address is granted
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_ad = 11'h000; cpu_dw = 8'h11;
        #2;
        checks++;
        if (ram_we !== 2'b01) begin errors++; $display("FAIL rst_pre_we: got %b expected %b", ram_we, 2'b01); end
        #1;
        RESET = 1'b1;
        cpu_req = 1'b0;
        #1;
        checks++;
        if (ram_we !== 2'b00) begin errors++; $display("FAIL rst_mid_we: got %b expected %b", ram_we, 2'b00); end
        cyc();
        RESET = 1'b0;
        for (int i = 0; i < 9; i++) begin
            #2;
            checks++;
            if (cpu_ack !== 1'b0 || ram_we !== 2'b00) begin
                errors++; $display("FAIL rst_post cycle %0d: got ack=%b we=%b expected ack=0 we=00", i, cpu_ack, ram_we);
            end
            cyc();
        end
        checks++;
        if (vid0_dt !== 16'h0000) begin errors++; $display("FAIL rst_vid0: got %h expected %h", vid0_dt, 16'h0000); end
    endtask

    task automatic test_video();
        ram_dr = 16'hA5C3; vid0_ad = 10'h155; vid1_ad = 10'h2AA;
        align();
        #2;
        checks++;
        if (ram_ad !== 10'h155 || ram_we !== 2'b00) begin errors++; $display("FAIL vid0_ad: got %h/%b expected 155/00", ram_ad, ram_we); end
        cyc();
        cyc();
        #2;
        checks++;
        if (vid0_dt !== 16'hA5C3) begin errors++; $display("FAIL vid0_dt: got %h expected %h", vid0_dt, 16'hA5C3); end
        cyc();
        cyc();
        ram_dr = 16'h1234;
        #2;
        checks++;
        if (ram_ad !== 10'h2AA || ram_we !== 2'b00) begin errors++; $display("FAIL vid1_ad: got %h/%b expected 2aa/00", ram_ad, ram_we); end
        cyc();
        cyc();
        #2;
        checks++;
        if (vid1_dt !== 16'h1234 || vid0_dt !== 16'hA5C3) begin errors++; $display("FAIL vid1_dt: got %h/%h expected 1234/a5c3", vid1_dt, vid0_dt); end
    endtask

    task automatic test_cpu_write();
        align();
        for (int i = 0; i < 8; i++) cyc();
        // request becomes visible at the slot-7 -> slot-0 boundary
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_ad = 11'h7FF; cpu_dw = 8'h3C;
        #2;
        checks++;
        if (ram_we !== 2'b00 || ram_ad !== 10'h155) begin errors++; $display("FAIL wr_slot0: got %h/%b expected 155/00", ram_ad, ram_we); end
        cyc();
        #2;
        checks++;
        if (ram_ad !== 10'h3FF || ram_we !== 2'b10 || ram_dw !== 16'h3C3C) begin
            errors++; $display("FAIL wr_grant: got %h/%b/%h expected 3ff/10/3c3c", ram_ad, ram_we, ram_dw);
        end
        checks++;
        if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_early_ack: got %b expected 0", cpu_ack); end
        cyc();
        cpu_req = 1'b0;
        #2;
        checks++;
        if (cpu_ack !== 1'b1 || ram_we !== 2'b00 || ram_ad !== 10'h3FF) begin
            errors++; $display("FAIL wr_ack: got ack=%b we=%b ad=%h expected 1/00/3ff", cpu_ack, ram_we, ram_ad);
        end
        cyc();
        #2;
        checks++;
        if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_len: got %b expected 0", cpu_ack); end
    endtask

    task automatic test_cpu_read();
        align();
        cyc();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_ad = 11'h001;
        #2;
        checks++;
        if (ram_ad !== 10'h000 || ram_we !== 2'b00) begin errors++; $display("FAIL rd_grant: got %h/%b expected 000/00", ram_ad, ram_we); end
        cyc();
        cpu_req = 1'b0; ram_dr = 16'hBEEF;
        #2;
        checks++;
        if (cpu_ack !== 1'b1 || cpu_dr !== 8'hBE) begin errors++; $display("FAIL rd_ack: got ack=%b dr=%h expected 1/be", cpu_ack, cpu_dr); end
        cyc();
        ram_dr = 16'h0000;
        #2;
        checks++;
        if (cpu_ack !== 1'b0 || cpu_dr !== 8'hBE) begin errors++; $display("FAIL rd_hold: got ack=%b dr=%h expected 0/be", cpu_ack, cpu_dr); end
    endtask

    task automatic test_contention();
        // 0 = video slot, 1 = CPU grant, 2 = hiscore grant
        int exp_g [8] = '{0, 1, 2, 1, 0, 2, 1, 2};
        int prev_g;
        logic [9:0] exp_ad;
        pause_n = 1'b0;
        cpu_we = 1'b0; hs_we = 1'b0; cpu_ad = 11'h010; hs_ad = 11'h020;
        #3;
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        cpu_req = 1'b1; hs_req = 1'b1;
        prev_g = 0;
        for (int i = 0; i < 16; i++) begin
            #2;
            case (exp_g[i % 8])
                0:       exp_ad = ((i % 8) == 0) ? 10'h155 : 10'h2AA;
                1:       exp_ad = 10'h008;
                default: exp_ad = 10'h010;
            endcase
            checks++;
            if (ram_ad !== exp_ad) begin errors++; $display("FAIL rr_grant cycle %0d: got ad=%h expected %h", i, ram_ad, exp_ad); end
            checks++;
            if (cpu_ack !== (prev_g == 1) || hs_ack !== (prev_g == 2)) begin
                errors++; $display("FAIL rr_ack cycle %0d: got cpu=%b hs=%b expected cpu=%b hs=%b", i, cpu_ack, hs_ack, prev_g == 1, prev_g == 2);
            end
            prev_g = exp_g[i % 8];
            cyc();
        end
        cpu_req = 1'b0; hs_req = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_pause();
        int seen;
        pause_n = 1'b1; hs_req = 1'b1; hs_we = 1'b0; hs_ad = 11'h003; ram_dr = 16'hC3A5;
        for (int i = 0; i < 32; i++) begin
            #2;
            checks++;
            if (hs_ack !== 1'b0) begin errors++; $display("FAIL pause_gate cycle %0d: got %b expected 0", i, hs_ack); end
            cyc();
        end
        pause_n = 1'b0;
        seen = -1;
        for (int k = 0; k < 4; k++) begin
            #2;
            if (hs_ack === 1'b1 && seen < 0) begin
                seen = k;
                hs_req = 1'b0;
                checks++;
                if (hs_dr !== 8'hC3) begin errors++; $display("FAIL pause_dr: got %h expected %h", hs_dr, 8'hC3); end
            end
            cyc();
        end
        hs_req = 1'b0;
        checks++;
        if (seen < 0) begin errors++; $display("FAIL pause_release: got no hs_ack expected ack within 3 cycles"); end
    endtask

    task automatic test_slot_sync();
        vid0_ad = 10'h0F0; vid1_ad = 10'h30F;
        align();
        for (int i = 0; i < 5; i++) cyc();
        #2;
        checks++;
        if (ram_ad !== 10'h30F) begin errors++; $display("FAIL sync_pre: got %h expected %h", ram_ad, 10'h30F); end
        // still in slot 5: realign and expect an immediate BG0 slot
        slot_sync = 1'b1;
        cyc();
        slot_sync = 1'b0;
        #2;
        checks++;
        if (ram_ad !== 10'h0F0 || ram_we !== 2'b00) begin errors++; $display("FAIL sync_slot0: got %h/%b expected 0f0/00", ram_ad, ram_we); end
    endtask

    initial begin
        RESET = 1'b1; slot_sync = 1'b0; vid0_ad = 10'h000; vid1_ad = 10'h000;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_ad = 11'h000; cpu_dw = 8'h00;
        hs_req = 1'b0; hs_we = 1'b0; hs_ad = 11'h000; hs_dw = 8'h00;
        pause_n = 1'b1; ram_dr = 16'h0000;
        #1;
        test_reset();
        test_video();
        test_cpu_write();
        test_cpu_read();
        test_contention();
        test_pause();
        test_slot_sync();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
